// File: rtl/rn_pkg.sv
// ----------------------------------------------------------------------------
// rn_pkg
// Shared definitions for the rn_node routing/arithmetic node:
//   - rn_mode_t  : operating mode encodings (matches the cfg_mode port coding)
//   - rn_state_t : configuration FSM state encodings
//   - lane-valid patterns emitted alongside each result beat
// ----------------------------------------------------------------------------
package rn_pkg;

    typedef enum logic [1:0] {
        RN_BYPASS = 2'b00,
        RN_ADD_L  = 2'b01,
        RN_ADD_R  = 2'b10,
        RN_DROP   = 2'b11
    } rn_mode_t;

    typedef enum logic [1:0] {
        ST_UNCFG = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } rn_state_t;

    // {left, right} lane-carries-data flags per mode
    localparam logic [1:0] LANES_BOTH  = 2'b11;
    localparam logic [1:0] LANES_LEFT  = 2'b10;
    localparam logic [1:0] LANES_RIGHT = 2'b01;
    localparam logic [1:0] LANES_NONE  = 2'b00;

endpackage : rn_pkg

// File: rtl/rn_skid_buf.sv
// ----------------------------------------------------------------------------
// rn_skid_buf
// Two-entry valid/ready output buffer (main + skid register), order preserving.
// The upstream ready is a pure register output (skid entry empty), so there is
// no combinational path from out_ready to in_ready. out_data reads as zero
// whenever out_valid is low.
//
// Ports:
//   clk, reset         clock / synchronous active-high reset
//   in_valid, in_ready upstream handshake (in_ready registered)
//   in_data  [W]       upstream payload
//   out_valid, out_ready downstream handshake
//   out_data [W]       downstream payload (held while stalled, 0 when idle)
// ----------------------------------------------------------------------------
module rn_skid_buf #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_reg, main_valid_next;
    logic         skid_valid_reg, skid_valid_next;
    logic [W-1:0] main_data_reg,  main_data_next;
    logic [W-1:0] skid_data_reg,  skid_data_next;
    logic         push;
    logic         pop;

    assign in_ready  = ~skid_valid_reg;
    assign push      = in_valid & ~skid_valid_reg;
    assign pop       = main_valid_reg & out_ready;
    assign out_valid = main_valid_reg;
    assign out_data  = main_valid_reg ? main_data_reg : '0;

    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        main_data_next  = main_data_reg;
        skid_data_next  = skid_data_reg;
        if (!main_valid_reg || pop) begin
            // Main slot is free this cycle: refill from skid first to keep order.
            // A full skid implies push=0 (in_ready low), so nothing is lost.
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                skid_valid_next = 1'b0;
            end else begin
                main_valid_next = push;
                if (push) begin
                    main_data_next = in_data;
                end
            end
        end else if (push) begin
            // Main is stalled: park the new beat in the skid entry.
            skid_valid_next = 1'b1;
            skid_data_next  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            main_data_reg  <= main_data_next;
            skid_data_reg  <= skid_data_next;
        end
    end

endmodule : rn_skid_buf

// File: rtl/rn_node.sv
// ----------------------------------------------------------------------------
// rn_node
// Configurable two-lane node. Each accepted signed operand pair {left, right}
// is bypassed (sign-extended), summed into the left or right lane, or dropped,
// according to the mode active in the cycle of acceptance. Results leave one
// cycle later through a 2-entry skid buffer.
//
// A small FSM (UNCFG / RUN / DRAIN) owns the mode: a reconfiguration request
// in RUN is parked in a pending register and only takes effect once every
// buffered result has left, so no result is ever computed in one mode and
// labelled with another.
//
// Ports:
//   clk, reset            clock / synchronous active-high reset
//   cfg_en, cfg_mode[2]   configuration load request and requested mode
//   cfg_busy              high while unconfigured or draining
//   in_valid/in_ready     operand handshake, in_data[2*DW_IN] = {left, right}
//   out_valid/out_ready   result handshake, out_data[2*(DW_IN+1)] = {left, right}
//   out_lane_vld[2]       {left, right} lane-carries-data flags
// ----------------------------------------------------------------------------
module rn_node
    import rn_pkg::*;
#(
    parameter int DW_IN = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_en,
    input  logic [1:0]             cfg_mode,
    output logic                   cfg_busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*DW_IN-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*(DW_IN+1)-1:0] out_data,
    output logic [1:0]             out_lane_vld
);

    localparam int DW_OUT = DW_IN + 1;
    localparam int BW     = 2 * DW_OUT + 2;

    rn_state_t state_reg,   state_next;
    rn_mode_t  mode_reg,    mode_next;
    rn_mode_t  pending_reg, pending_next;

    logic [DW_OUT-1:0] lane_ext [2];   // [1] = left, [0] = right
    logic [DW_OUT-1:0] sum;
    logic [DW_OUT-1:0] res_left;
    logic [DW_OUT-1:0] res_right;
    logic [1:0]        res_lanes;

    logic          accept;
    logic          buf_in_valid;
    logic          buf_in_ready;
    logic [BW-1:0] buf_in_data;
    logic          buf_out_valid;
    logic [BW-1:0] buf_out_data;

    // ------------------------------------------------------------------
    // Datapath: sign-extend both lanes; the sum of two DW_IN-bit signed
    // values always fits in DW_IN+1 bits, so no saturation is needed.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_ext[gi] = {in_data[gi*DW_IN + DW_IN - 1], in_data[gi*DW_IN +: DW_IN]};
        end
    endgenerate

    assign sum = lane_ext[1] + lane_ext[0];

    always_comb begin
        res_left  = '0;
        res_right = '0;
        res_lanes = LANES_NONE;
        case (mode_reg)
            RN_BYPASS: begin
                res_left  = lane_ext[1];
                res_right = lane_ext[0];
                res_lanes = LANES_BOTH;
            end
            RN_ADD_L: begin
                res_left  = sum;
                res_lanes = LANES_LEFT;
            end
            RN_ADD_R: begin
                res_right = sum;
                res_lanes = LANES_RIGHT;
            end
            default: begin
                res_lanes = LANES_NONE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake. in_ready depends only on registers (FSM state, mode and
    // the buffer's registered ready). In DROP the buffer is never written,
    // so the node keeps accepting regardless of downstream backpressure.
    // ------------------------------------------------------------------
    assign in_ready     = (state_reg == ST_RUN) && ((mode_reg == RN_DROP) || buf_in_ready);
    assign accept       = in_valid & in_ready;
    assign buf_in_valid = accept && (mode_reg != RN_DROP);
    assign buf_in_data  = {res_lanes, res_left, res_right};

    rn_skid_buf #(
        .W (BW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (buf_in_data),
        .out_valid (buf_out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out_data)
    );

    // The buffer zeroes its payload when empty, so these are 0 when idle.
    assign out_valid    = buf_out_valid;
    assign out_data     = buf_out_data[2*DW_OUT-1:0];
    assign out_lane_vld = buf_out_data[BW-1 -: 2];
    assign cfg_busy     = (state_reg != ST_RUN);

    // ------------------------------------------------------------------
    // Configuration FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        pending_next = pending_reg;
        case (state_reg)
            ST_UNCFG: begin
                if (cfg_en) begin
                    mode_next  = rn_mode_t'(cfg_mode);
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A pair accepted this cycle still uses mode_reg.
                if (cfg_en) begin
                    pending_next = rn_mode_t'(cfg_mode);
                    state_next   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cfg_en) begin
                    pending_next = rn_mode_t'(cfg_mode);
                end
                // Buffer empty <=> main entry empty (skid never holds alone).
                if (!buf_out_valid) begin
                    mode_next  = pending_next;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_UNCFG;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_UNCFG;
            mode_reg    <= RN_BYPASS;
            pending_reg <= RN_BYPASS;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            pending_reg <= pending_next;
        end
    end

endmodule : rn_node

// File: tb/tb_rn_node.sv
// ----------------------------------------------------------------------------
// tb_rn_node
// Self-checking bench for rn_node: a table of single-pair vectors covering
// every arithmetic mode and the signed extremes, followed by hand-written
// sequences for back-to-back streaming, backpressure, reconfiguration while
// results are buffered, DROP mode and reset with buffered results.
// ----------------------------------------------------------------------------
module tb_rn_node;

    localparam int DW_IN = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_en = 1'b0;
    logic [1:0]  cfg_mode = 2'b00;
    logic        cfg_busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [17:0] out_data;
    logic [1:0]  out_lane_vld;

    int passed = 0;
    int total  = 0;

    rn_node #(
        .DW_IN (DW_IN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_en       (cfg_en),
        .cfg_mode     (cfg_mode),
        .cfg_busy     (cfg_busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_lane_vld (out_lane_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         l;
        int         r;
        int         exp_l;
        int         exp_r;
        logic [1:0] exp_lanes;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] pk(input int l, input int r);
        logic [31:0] a;
        logic [31:0] b;
        a = l;
        b = r;
        return {a[8:0], b[8:0]};
    endfunction

    function automatic logic [15:0] pair(input int l, input int r);
        logic [31:0] a;
        logic [31:0] b;
        a = l;
        b = r;
        return {a[7:0], b[7:0]};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Request a mode and wait (bounded) until the node is back in RUN.
    task automatic configure(input logic [1:0] m);
        int n;
        cfg_en   = 1'b1;
        cfg_mode = m;
        step();
        cfg_en = 1'b0;
        n = 0;
        while (cfg_busy && n < 8) begin
            step();
            n++;
        end
        chk("cfg_done", {31'd0, cfg_busy}, 32'd0);
    endtask

    task automatic wait_in_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 8) begin
            chk({name, "_no_out"}, {31'd0, out_valid}, 32'd0);
            step();
            n++;
        end
        chk(name, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int pl [4];
        int pr [4];

        //               mode   l     r    exp_l exp_r lanes
        vecs[0] = '{2'b01,  100,   50,  150,    0, 2'b10};
        vecs[1] = '{2'b10, -128, -128,    0, -256, 2'b01};
        vecs[2] = '{2'b00,   -1,  127,   -1,  127, 2'b11};
        vecs[3] = '{2'b00, -128,    0, -128,    0, 2'b11};
        vecs[4] = '{2'b01,  127,  127,  254,    0, 2'b10};
        vecs[5] = '{2'b01, -128,   -1, -129,    0, 2'b10};
        vecs[6] = '{2'b10,  127, -128,    0,   -1, 2'b01};
        vecs[7] = '{2'b10,   -5,    5,    0,    0, 2'b01};

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {14'd0, out_data}, 32'd0);
        chk("rst_lane_vld", {30'd0, out_lane_vld}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cfg_busy", {31'd0, cfg_busy}, 32'd1);
        // UNCFG ignores operands
        in_valid = 1'b1;
        in_data  = pair(1, 1);
        step();
        in_valid = 1'b0;
        chk("uncfg_no_out", {31'd0, out_valid}, 32'd0);

        // ---------------- single-pair vector table ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            configure(vecs[i].mode);
            in_valid = 1'b1;
            in_data  = pair(vecs[i].l, vecs[i].r);
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_out_data", i), {14'd0, out_data}, {14'd0, pk(vecs[i].exp_l, vecs[i].exp_r)});
            chk($sformatf("v%0d_lanes", i), {30'd0, out_lane_vld}, {30'd0, vecs[i].exp_lanes});
            step();
            chk($sformatf("v%0d_idle", i), {31'd0, out_valid}, 32'd0);
        end

        // ---------------- BYPASS: 4 back-to-back pairs ----------------
        pl = '{1, -3, 5, -100};
        pr = '{-2, 4, -6, 100};
        configure(2'b00);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = pair(pl[i], pr[i]);
            chk($sformatf("b2b%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            chk($sformatf("b2b%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("b2b%0d_out_data", i), {14'd0, out_data}, {14'd0, pk(pl[i], pr[i])});
            chk($sformatf("b2b%0d_lanes", i), {30'd0, out_lane_vld}, 32'd3);
        end
        in_valid = 1'b0;
        step();
        chk("b2b_idle", {31'd0, out_valid}, 32'd0);

        // ---------------- backpressure: out_ready=0 for 3 cycles ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pair(10, -10);
        step();
        chk("bp_e1_data", {14'd0, out_data}, {14'd0, pk(10, -10)});
        chk("bp_e1_in_ready", {31'd0, in_ready}, 32'd1);
        in_data = pair(20, -20);
        step();
        chk("bp_e2_data", {14'd0, out_data}, {14'd0, pk(10, -10)});
        chk("bp_e2_in_ready", {31'd0, in_ready}, 32'd0);
        in_data = pair(30, -30);
        step();
        chk("bp_e3_data", {14'd0, out_data}, {14'd0, pk(10, -10)});
        chk("bp_e3_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_e4_data", {14'd0, out_data}, {14'd0, pk(20, -20)});
        chk("bp_e4_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_e5_data", {14'd0, out_data}, {14'd0, pk(30, -30)});
        step();
        chk("bp_e6_idle", {31'd0, out_valid}, 32'd0);

        // ---------------- reconfigure to DROP with 2 results buffered ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pair(7, 8);
        step();
        // pair accepted together with cfg_en uses the old (BYPASS) mode
        in_data  = pair(-7, -8);
        cfg_en   = 1'b1;
        cfg_mode = 2'b11;
        step();
        in_valid = 1'b0;
        chk("drn_busy", {31'd0, cfg_busy}, 32'd1);
        chk("drn_in_ready0", {31'd0, in_ready}, 32'd0);
        chk("drn_data0", {14'd0, out_data}, {14'd0, pk(7, 8)});
        // a later request in DRAIN overwrites the pending mode
        cfg_mode = 2'b01;
        step();
        chk("drn_in_ready1", {31'd0, in_ready}, 32'd0);
        cfg_mode  = 2'b11;
        out_ready = 1'b1;
        step();
        cfg_en = 1'b0;
        chk("drn_data1", {14'd0, out_data}, {14'd0, pk(-7, -8)});
        chk("drn_lanes1", {30'd0, out_lane_vld}, 32'd3);
        chk("drn_in_ready2", {31'd0, in_ready}, 32'd0);
        step();
        chk("drn_empty", {31'd0, out_valid}, 32'd0);
        wait_in_ready("drn_to_run");
        chk("drop_cfg_busy", {31'd0, cfg_busy}, 32'd0);

        // DROP: pairs consumed, never an output beat, even with out_ready=0
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = pair(i + 1, i + 2);
            chk($sformatf("drop%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            chk($sformatf("drop%0d_no_out", i), {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        step();
        chk("drop_idle", {31'd0, out_valid}, 32'd0);

        // ---------------- reset with 2 results buffered ----------------
        out_ready = 1'b1;
        configure(2'b00);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pair(11, 12);
        step();
        in_data = pair(13, 14);
        step();
        chk("rb_full", {31'd0, in_ready}, 32'd0);
        // reset wins over cfg_en and in_valid
        reset    = 1'b1;
        cfg_en   = 1'b1;
        cfg_mode = 2'b01;
        out_ready = 1'b1;
        step();
        reset  = 1'b0;
        cfg_en = 1'b0;
        in_valid = 1'b0;
        chk("rb_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rb_out_data", {14'd0, out_data}, 32'd0);
        chk("rb_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rb_cfg_busy", {31'd0, cfg_busy}, 32'd1);
        step();
        chk("rb_still_uncfg", {31'd0, cfg_busy}, 32'd1);
        chk("rb_no_beat", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_rn_node
